// File: rtl/if_id.sv
// IF/ID pipeline register: captures the fetched PC and instruction each cycle,
// with hold (stall) and bubble insertion (flush) for hazard and branch control.
module if_id #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   NOP_WORD = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [WIDTH-1:0] IR_IN,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] IR_OUT,
    output logic             VALID_OUT
);

    // Flush outranks Stall so a squashed fetch never lingers behind a hold.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            PC_OUT    <= {WIDTH{1'b0}};
            IR_OUT    <= NOP_WORD;
            VALID_OUT <= 1'b0;
        end else if (Flush) begin
            PC_OUT    <= {WIDTH{1'b0}};
            IR_OUT    <= NOP_WORD;
            VALID_OUT <= 1'b0;
        end else if (!Stall) begin
            PC_OUT    <= PC_IN;
            IR_OUT    <= IR_IN;
            VALID_OUT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id.sv
// Bench for if_id: directed scenarios from the test plan plus a randomized run,
// checked against a history-of-accepted-entries reference model.
module tb_if_id;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst_n, Stall, Flush;
    logic [W-1:0] PC_IN, IR_IN, PC_OUT, IR_OUT;
    logic         VALID_OUT;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] ir;
        logic         v;
    } ent_t;

    ent_t hist[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_id #(.WIDTH(W), .NOP_WORD(32'h0000_0000)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .PC_IN(PC_IN), .IR_IN(IR_IN),
        .PC_OUT(PC_OUT), .IR_OUT(IR_OUT), .VALID_OUT(VALID_OUT)
    );

    always #5 Clk = ~Clk;

    // Output shown to ID is always the most recent entry the register accepted.
    function automatic ent_t model_out();
        ent_t e;
        if (hist.size() == 0) begin
            e.pc = 'x; e.ir = 'x; e.v = 1'bx;
        end else begin
            e = hist[$];
        end
        return e;
    endfunction

    task automatic tick();
        ent_t e;
        if (!Rst_n) begin
            hist.delete();
            e.pc = '0; e.ir = 32'h0000_0000; e.v = 1'b0;
            hist.push_back(e);
        end else if (Flush) begin
            e.pc = '0; e.ir = 32'h0000_0000; e.v = 1'b0;
            hist.push_back(e);
        end else if (!Stall) begin
            e.pc = PC_IN; e.ir = IR_IN; e.v = 1'b1;
            hist.push_back(e);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ent_t e;
        Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        PC_IN = 500; IR_IN = 600;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = model_out();
            n_cmp++;
            if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b0, 32'd0, 32'd0} ||
                {VALID_OUT, IR_OUT, PC_OUT} !== {e.v, e.ir, e.pc}) begin
                n_err++;
                $display("FAIL reset_edge%0d: got pc=%0d ir=%0d v=%b want pc=0 ir=0 v=0",
                         i, PC_OUT, IR_OUT, VALID_OUT);
            end
        end
    endtask

    task automatic test_normal_load();
        ent_t e;
        Rst_n = 1'b1; PC_IN = 500; IR_IN = 600;
        tick();
        e = model_out();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'd600, 32'd500}) begin
            n_err++;
            $display("FAIL load_500_600: got pc=%0d ir=%0d v=%b want pc=500 ir=600 v=1",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
        PC_IN = 3100; IR_IN = 62300;
        #2;
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {e.v, e.ir, e.pc}) begin
            n_err++;
            $display("FAIL load_hold_between_edges: got pc=%0d ir=%0d v=%b want pc=%0d ir=%0d v=%b",
                     PC_OUT, IR_OUT, VALID_OUT, e.pc, e.ir, e.v);
        end
        tick();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'd62300, 32'd3100}) begin
            n_err++;
            $display("FAIL load_3100_62300: got pc=%0d ir=%0d v=%b want pc=3100 ir=62300 v=1",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
    endtask

    task automatic test_stall();
        ent_t e;
        Stall = 1'b1; PC_IN = 7; IR_IN = 8;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = model_out();
            n_cmp++;
            if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'd62300, 32'd3100} ||
                {VALID_OUT, IR_OUT, PC_OUT} !== {e.v, e.ir, e.pc}) begin
                n_err++;
                $display("FAIL stall_cycle%0d: got pc=%0d ir=%0d v=%b want pc=3100 ir=62300 v=1",
                         i, PC_OUT, IR_OUT, VALID_OUT);
            end
        end
        Stall = 1'b0;
        tick();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'd8, 32'd7}) begin
            n_err++;
            $display("FAIL stall_release: got pc=%0d ir=%0d v=%b want pc=7 ir=8 v=1",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
    endtask

    task automatic test_flush_priority();
        PC_IN = 500; IR_IN = 600;
        tick();
        Stall = 1'b1; Flush = 1'b1;
        tick();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL flush_over_stall: got pc=%0d ir=%0d v=%b want pc=0 ir=0 v=0",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
        Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_sync_reset_timing();
        ent_t e;
        PC_IN = 1234; IR_IN = 5678;
        tick();
        // Reset pulse fully between two edges, then inputs held for a stall edge.
        Stall = 1'b1;
        #1 Rst_n = 1'b0;
        #2 Rst_n = 1'b1;
        tick();
        e = model_out();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'd5678, 32'd1234} ||
            {VALID_OUT, IR_OUT, PC_OUT} !== {e.v, e.ir, e.pc}) begin
            n_err++;
            $display("FAIL rst_pulse_no_edge: got pc=%0d ir=%0d v=%b want pc=1234 ir=5678 v=1",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
        Rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL rst_during_stall: got pc=%0d ir=%0d v=%b want pc=0 ir=0 v=0",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
        Rst_n = 1'b1; Stall = 1'b0;
    endtask

    task automatic test_full_width();
        PC_IN = 32'hFFFF_FFFC; IR_IN = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if ({VALID_OUT, IR_OUT, PC_OUT} !== {1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL full_width: got pc=%h ir=%h v=%b want pc=fffffffc ir=deadbeef v=1",
                     PC_OUT, IR_OUT, VALID_OUT);
        end
    endtask

    task automatic test_random();
        ent_t e;
        for (int i = 0; i < 300; i++) begin
            Rst_n = ($urandom_range(0, 19) != 0);
            Stall = ($urandom_range(0, 9) < 3);
            Flush = ($urandom_range(0, 9) == 0);
            PC_IN = $urandom();
            IR_IN = $urandom();
            tick();
            e = model_out();
            n_cmp++;
            if ({VALID_OUT, IR_OUT, PC_OUT} !== {e.v, e.ir, e.pc}) begin
                n_err++;
                $display("FAIL random_cycle%0d: got pc=%h ir=%h v=%b want pc=%h ir=%h v=%b",
                         i, PC_OUT, IR_OUT, VALID_OUT, e.pc, e.ir, e.v);
            end
        end
        Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_stall();
        test_flush_priority();
        test_sync_reset_timing();
        test_full_width();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
